// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//
// Registered stage that sits directly after the 8-bit ALU. Each ALU beat
// (result, writeback tag) is captured into a 2-entry skid buffer behind a
// valid/ready handshake, so a stalled writeback never loses a beat. The
// architectural flag register (flag_zero, flag_lt) read by the branch logic
// is also kept here. It is updated when a beat is accepted, not when the beat
// is written back.
//
// Parameters
//   DW  data width; must match the ALU operand/result width
//   AW  register-file address width of the writeback destination
//
// Ports
//   clk        single clock; all state updates on posedge
//   rst_n      asynchronous, active-low reset
//   in_valid   upstream: ALU beat present
//   in_ready   upstream: stage can accept a beat this cycle (registered)
//   alu_out    ALU result
//   alu_zero   ALU Zero (result == 0)
//   alu_lt     ALU LT (A < B, unsigned)
//   dest_reg   writeback register index
//   wr_en      beat writes the register file
//   set_flags  beat updates the flag register
//   out_valid  downstream: writeback beat present
//   out_ready  downstream: writeback consumes the beat this cycle
//   wb_data    registered result (the last main-entry contents while idle)
//   wb_dest    registered destination
//   wb_wr_en   registered write enable
//   flag_zero  architectural Zero flag
//   flag_lt    architectural LT flag
// -----------------------------------------------------------------------------
module alu_result_stage #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_zero,
  input  logic          alu_lt,
  input  logic [AW-1:0] dest_reg,
  input  logic          wr_en,
  input  logic          set_flags,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] wb_data,
  output logic [AW-1:0] wb_dest,
  output logic          wb_wr_en,
  output logic          flag_zero,
  output logic          flag_lt
);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] dest;
    logic          wr_en;
  } entry_t;

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q;
  logic   accept;
  logic   consume;

  assign in_entry = '{data: alu_out, dest: dest_reg, wr_en: wr_en};
  assign accept   = in_valid & in_ready_q;
  assign consume  = main_valid_q & out_ready;

  // Next-state of the two-entry buffer. The skid entry is only ever filled
  // while main is held, and in_ready is low whenever skid is occupied, so a
  // new beat can never arrive in the same cycle skid drains into main.
  // NOTE: every signal assigned here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (consume) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = in_entry;
      end
    end else if (main_valid_q) begin
      if (accept) begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end
    end else if (accept) begin
      main_d       = in_entry;
      main_valid_d = 1'b1;
    end
  end

  // in_ready is registered from the next skid state, which keeps out_ready
  // off any combinational path to in_ready. It resets low and rises on the
  // first edge after reset release.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  // Flags follow issue order, not writeback order: the next instruction must
  // see them one cycle after issue even while its producer is still buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_zero <= 1'b0;
      flag_lt   <= 1'b0;
    end else if (accept && set_flags) begin
      flag_zero <= alu_zero;
      flag_lt   <= alu_lt;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign wb_data   = main_q.data;
  assign wb_dest   = main_q.dest;
  assign wb_wr_en  = main_q.wr_en;

endmodule

// File: tb/tb_alu_result_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_result_stage
//
// Directed bench for alu_result_stage. Inputs change 1 ns after each rising
// edge, and outputs are sampled at that same point, once the registers have
// settled.
// -----------------------------------------------------------------------------
module tb_alu_result_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] alu_out;
  logic       alu_zero;
  logic       alu_lt;
  logic [2:0] dest_reg;
  logic       wr_en;
  logic       set_flags;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] wb_data;
  logic [2:0] wb_dest;
  logic       wb_wr_en;
  logic       flag_zero;
  logic       flag_lt;

  int n_cmp = 0;
  int n_err = 0;

  alu_result_stage #(.DW(8), .AW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .alu_lt    (alu_lt),
    .dest_reg  (dest_reg),
    .wr_en     (wr_en),
    .set_flags (set_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wb_data   (wb_data),
    .wb_dest   (wb_dest),
    .wb_wr_en  (wb_wr_en),
    .flag_zero (flag_zero),
    .flag_lt   (flag_lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic z, input logic lt,
                            input logic [2:0] dst, input logic we, input logic sf);
    in_valid  = 1'b1;
    alu_out   = d;
    alu_zero  = z;
    alu_lt    = lt;
    dest_reg  = dst;
    wr_en     = we;
    set_flags = sf;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    set_flags = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    idle();
    alu_out   = '0;
    alu_zero  = 1'b0;
    alu_lt    = 1'b0;
    dest_reg  = '0;
    wr_en     = 1'b0;
    repeat (2) step();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++;
    if (wb_data !== 8'h00) begin n_err++; $display("FAIL reset_wb_data: got %h want 00", wb_data); end
    n_cmp++;
    if (wb_dest !== 3'd0 || wb_wr_en !== 1'b0) begin
      n_err++; $display("FAIL reset_wb_tag: got dest=%0d we=%b want 0/0", wb_dest, wb_wr_en);
    end
    n_cmp++;
    if (flag_zero !== 1'b0 || flag_lt !== 1'b0) begin
      n_err++; $display("FAIL reset_flags: got z=%b lt=%b want 0/0", flag_zero, flag_lt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive_beat(8'h2A, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1);
    step();
    idle();
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_cmp++;
    if (wb_data !== 8'h2A || wb_dest !== 3'd3 || wb_wr_en !== 1'b1) begin
      n_err++; $display("FAIL single_wb: got %h/%0d/%b want 2a/3/1", wb_data, wb_dest, wb_wr_en);
    end
    n_cmp++;
    if (flag_zero !== 1'b0 || flag_lt !== 1'b1) begin
      n_err++; $display("FAIL single_flags: got z=%b lt=%b want 0/1", flag_zero, flag_lt);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_cmp++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
      drive_beat(8'(i), 1'b0, 1'b0, 3'(i), 1'b1, 1'b0);
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || wb_data !== 8'(i)) begin
        n_err++; $display("FAIL b2b_data[%0d]: got v=%b d=%h want 1/%h", i, out_valid, wb_data, 8'(i));
      end
    end
    idle();
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive_beat(8'h10, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || wb_data !== 8'h10 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL stall_first: got v=%b d=%h rdy=%b want 1/10/1", out_valid, wb_data, in_ready);
    end
    drive_beat(8'h11, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
    step();
    n_cmp++;
    if (in_ready !== 1'b0 || wb_data !== 8'h10) begin
      n_err++; $display("FAIL stall_full: got rdy=%b d=%h want 0/10", in_ready, wb_data);
    end
    drive_beat(8'h12, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0);
    step();
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || wb_data !== 8'h10 || wb_dest !== 3'd1) begin
      n_err++; $display("FAIL stall_hold: got rdy=%b v=%b d=%h dst=%0d want 0/1/10/1",
                        in_ready, out_valid, wb_data, wb_dest);
    end
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (wb_data !== 8'h11 || wb_dest !== 3'd2 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL stall_skid_move: got d=%h dst=%0d rdy=%b want 11/2/1", wb_data, wb_dest, in_ready);
    end
    step();
    idle();
    n_cmp++;
    if (out_valid !== 1'b1 || wb_data !== 8'h12) begin
      n_err++; $display("FAIL stall_late_beat: got v=%b d=%h want 1/12", out_valid, wb_data);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_drain: got %b want 0", out_valid); end
  endtask

  // Leaves both entries occupied for test_reset_mid.
  task automatic test_flags_on_accept();
    out_ready = 1'b0;
    drive_beat(8'h00, 1'b1, 1'b0, 3'd5, 1'b1, 1'b1);
    step();
    n_cmp++;
    if (flag_zero !== 1'b1 || flag_lt !== 1'b0 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL flags_main: got z=%b lt=%b v=%b want 1/0/1", flag_zero, flag_lt, out_valid);
    end
    drive_beat(8'h77, 1'b1, 1'b1, 3'd6, 1'b1, 1'b1);
    step();
    idle();
    n_cmp++;
    if (flag_zero !== 1'b1 || flag_lt !== 1'b1 || wb_data !== 8'h00 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL flags_skid: got z=%b lt=%b d=%h rdy=%b want 1/1/00/0",
                        flag_zero, flag_lt, wb_data, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || flag_zero !== 1'b0 || flag_lt !== 1'b0) begin
      n_err++; $display("FAIL midreset_async: got v=%b z=%b lt=%b want 0/0/0", out_valid, flag_zero, flag_lt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL midreset_release: got rdy=%b v=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_flags_hold();
    out_ready = 1'b1;
    drive_beat(8'h00, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1);
    step();
    n_cmp++;
    if (flag_zero !== 1'b1 || flag_lt !== 1'b1) begin
      n_err++; $display("FAIL hold_setup: got z=%b lt=%b want 1/1", flag_zero, flag_lt);
    end
    drive_beat(8'h5A, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0);
    step();
    idle();
    n_cmp++;
    if (flag_zero !== 1'b1 || flag_lt !== 1'b1) begin
      n_err++; $display("FAIL hold_flags: got z=%b lt=%b want 1/1", flag_zero, flag_lt);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || wb_data !== 8'h5A || wb_dest !== 3'd6 || wb_wr_en !== 1'b0) begin
      n_err++; $display("FAIL hold_wb: got v=%b d=%h dst=%0d we=%b want 1/5a/6/0",
                        out_valid, wb_data, wb_dest, wb_wr_en);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_flags_on_accept();
    test_reset_mid();
    test_flags_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
